// File: rtl/conv_pkg.sv
// Shared definitions for the PE-array feed path.
// Contents: pixel/window-row widths, feeder FSM state encoding and the
// packed type for one 3-pixel window column (oldest line in the top field).
package conv_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned WIN_ROW_W = 24;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } feeder_state_e;

  // One vertical slice of the 3x3 window: top = oldest line, bot = newest.
  typedef struct packed {
    logic [PIX_W-1:0] top;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] bot;
  } win_col_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage for the window feeder.
// Ports:
//   clk        - write clock
//   wr_en      - write enable, stores wr_data at addr on the rising edge
//   addr       - shared read/write column address
//   wr_data    - pixel to store
//   rd_data_c  - combinational read of the current contents at addr
// The read is asynchronous, so a same-address write returns the old value
// until the edge.
module line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic [PIX_W-1:0]  rd_data_c
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Storage is never cleared; stale contents are overwritten before use.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

  assign rd_data_c = mem[addr];

endmodule

// File: rtl/conv_window_feeder.sv
// Streaming 3x3 window generator between the MM2S pixel stream and the PE
// array. Buffers two lines and emits three 24-bit window rows per interior
// pixel position, each row packed {c-2, c-1, c} with c-2 in [23:16].
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast - pixel stream in; s_axis_tready back-pressure
//   o_win_row_1/2/3          - oldest / middle / newest line of the window
//   o_win_valid, i_win_ready - window handshake towards the PE array
//   o_frame_done             - one-cycle pulse after the last window is taken
//   o_err                    - sticky tlast misalignment flag, only built when
//                              FEEDER_TLAST_CHECK_EN is defined
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PIX_W-1:0]     s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [WIN_ROW_W-1:0] o_win_row_1,
  output logic [WIN_ROW_W-1:0] o_win_row_2,
  output logic [WIN_ROW_W-1:0] o_win_row_3,
  output logic                 o_win_valid,
  input  logic                 i_win_ready,
  output logic                 o_frame_done
`ifdef FEEDER_TLAST_CHECK_EN
  ,
  output logic                 o_err
`endif
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned SH_W  = 2 * PIX_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  feeder_state_e    state, state_d;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept, col_last, row_last, win_fire, win_take;
  logic             frame_done_d;
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  win_col_t         new_col;
  logic [SH_W-1:0]  sh_1, sh_2, sh_3;

  assign s_axis_tready = (state != S_DONE) && (!o_win_valid || i_win_ready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign col_last      = (col == COL_LAST);
  assign row_last      = (row == ROW_LAST);
  assign win_fire      = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign win_take      = o_win_valid && i_win_ready;

  assign new_col.top = lb2_rd;
  assign new_col.mid = lb1_rd;
  assign new_col.bot = s_axis_tdata;

  // lb1 holds the previous line, lb2 the line before it.
  line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb1 (
    .clk       (clk),
    .wr_en     (accept),
    .addr      (col),
    .wr_data   (s_axis_tdata),
    .rd_data_c (lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb2 (
    .clk       (clk),
    .wr_en     (accept),
    .addr      (col),
    .wr_data   (lb1_rd),
    .rd_data_c (lb2_rd)
  );

  // Next-state logic.
  always_comb begin
    state_d      = state;
    frame_done_d = 1'b0;
    case (state)
      S_FILL: if (accept && (row >= ROW_W'(2)) && (col == COL_W'(1))) state_d = S_RUN;
      S_RUN:  if (accept && col_last) state_d = row_last ? S_DONE : S_FILL;
      S_DONE: if (win_take) begin
        state_d      = S_FILL;
        frame_done_d = 1'b1;
      end
      default: state_d = S_FILL;
    endcase
  end

  // State register, frame-done pulse and pixel position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FILL;
      o_frame_done <= 1'b0;
      col          <= '0;
      row          <= '0;
    end else begin
      state        <= state_d;
      o_frame_done <= frame_done_d;
      if ((state == S_DONE) && win_take) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Two previous window columns per line; the third comes straight from the
  // line buffers and the input pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_1 <= '0;
      sh_2 <= '0;
      sh_3 <= '0;
    end else if (accept) begin
      sh_1 <= {sh_1[PIX_W-1:0], new_col.top};
      sh_2 <= {sh_2[PIX_W-1:0], new_col.mid};
      sh_3 <= {sh_3[PIX_W-1:0], new_col.bot};
    end
  end

  // Output window: a new window overrides a taken one, else hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_win_row_1 <= '0;
      o_win_row_2 <= '0;
      o_win_row_3 <= '0;
      o_win_valid <= 1'b0;
    end else if (win_fire) begin
      o_win_row_1 <= {sh_1, new_col.top};
      o_win_row_2 <= {sh_2, new_col.mid};
      o_win_row_3 <= {sh_3, new_col.bot};
      o_win_valid <= 1'b1;
    end else if (win_take) begin
      o_win_valid <= 1'b0;
    end
  end

`ifdef FEEDER_TLAST_CHECK_EN
  // tlast must coincide exactly with the last column; counters ignore it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err <= 1'b0;
    end else if (accept && (s_axis_tlast != col_last)) begin
      o_err <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder on a 4x4 image. A frame-image model
// predicts every window from pixel positions; a negedge monitor checks the
// DUT each cycle and literal expectations pin selected windows.
module tb_conv_window_feeder;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [23:0] o_win_row_1, o_win_row_2, o_win_row_3;
  logic        o_win_valid;
  logic        i_win_ready;
  logic        o_frame_done;
`ifdef FEEDER_TLAST_CHECK_EN
  logic        o_err;
`endif

  always #5 clk = ~clk;

  conv_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .o_win_row_1   (o_win_row_1),
    .o_win_row_2   (o_win_row_2),
    .o_win_row_3   (o_win_row_3),
    .o_win_valid   (o_win_valid),
    .i_win_ready   (i_win_ready),
    .o_frame_done  (o_frame_done)
`ifdef FEEDER_TLAST_CHECK_EN
    ,
    .o_err         (o_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model state
  logic [7:0]  img [H][W];
  int          p = 0;
  logic        m_load = 1'b0, m_take = 1'b0, m_final = 1'b0, m_valid = 1'b0;
  logic [71:0] m_win, m_prev;
  logic        err_exp = 1'b0;
  int          wins_in_frame = 0;
  int          frame_idx = 0;
  int          done_pulses = 0;
  int          stall_obs = 0;
  int          stall_left = 0;
  logic [71:0] cap [8][4];
  int          mon_r, mon_c;
  logic        mon_acc;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the frame-image model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 72'(o_win_valid), 72'd0);
      chk("rst_rows", {o_win_row_1, o_win_row_2, o_win_row_3}, 72'd0);
      chk("rst_done", 72'(o_frame_done), 72'd0);
`ifdef FEEDER_TLAST_CHECK_EN
      chk("rst_err", 72'(o_err), 72'd0);
`endif
      p = 0; m_load = 0; m_take = 0; m_final = 0; m_valid = 0;
      err_exp = 0; wins_in_frame = 0;
    end else begin
      chk("win_valid", 72'(o_win_valid), 72'(m_load ? 1'b1 : (m_take ? 1'b0 : m_valid)));
      if (m_load)
        chk("win_data", {o_win_row_1, o_win_row_2, o_win_row_3}, m_win);
      else if (m_valid && !m_take)
        chk("win_hold", {o_win_row_1, o_win_row_2, o_win_row_3}, m_prev);
      chk("frame_done", 72'(o_frame_done), 72'(m_final));
      if (o_frame_done) done_pulses++;
      chk("tready", 72'(s_axis_tready), 72'((p != NPIX) && (!o_win_valid || i_win_ready)));
`ifdef FEEDER_TLAST_CHECK_EN
      chk("err", 72'(o_err), 72'(err_exp));
`endif
      if (o_win_valid && !i_win_ready && !s_axis_tready) stall_obs++;

      // Events at the coming rising edge
      mon_acc = s_axis_tvalid && s_axis_tready;
      m_take  = o_win_valid && i_win_ready;
      m_final = m_take && (p == NPIX);
      m_valid = o_win_valid;
      m_prev  = {o_win_row_1, o_win_row_2, o_win_row_3};
      m_load  = 1'b0;
      if (m_take) begin
        cap[frame_idx % 8][wins_in_frame % 4] = m_prev;
        wins_in_frame++;
      end
      if (m_final) begin
        chk("wins_per_frame", 72'(wins_in_frame), 72'((W - 2) * (H - 2)));
        wins_in_frame = 0;
        frame_idx++;
        p = 0;
      end
      if (mon_acc) begin
        mon_r = p / W;
        mon_c = p % W;
        img[mon_r][mon_c] = s_axis_tdata;
`ifdef FEEDER_TLAST_CHECK_EN
        if (s_axis_tlast != (mon_c == W - 1)) err_exp = 1'b1;
`endif
        if (mon_r >= 2 && mon_c >= 2) begin
          m_load = 1'b1;
          m_win  = {img[mon_r-2][mon_c-2], img[mon_r-2][mon_c-1], img[mon_r-2][mon_c],
                    img[mon_r-1][mon_c-2], img[mon_r-1][mon_c-1], img[mon_r-1][mon_c],
                    img[mon_r][mon_c-2],   img[mon_r][mon_c-1],   img[mon_r][mon_c]};
        end
        p++;
      end
    end
  end

  // PE-side ready: stalls while the second window of a frame is presented.
  initial begin
    i_win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && o_win_valid && wins_in_frame == 1) begin
        i_win_ready = 1'b0;
        stall_left--;
      end else begin
        i_win_ready = 1'b1;
      end
    end
  end

  task automatic send_px(input logic [7:0] d, input logic last);
    logic fire;
    int   n;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    fire = 1'b0;
    n    = 0;
    while (!fire && n < 200) begin
      @(negedge clk);
      fire = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!fire) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: pixel %h not accepted in %0d cycles", d, n);
    end
  endtask

  task automatic send_frame(input int base, input int bad_last, input int count);
    for (int i = 0; i < count; i++)
      send_px(8'(base + i + 1), (i % W == W - 1) || (i == bad_last));
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (frame_idx < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (frame_idx < n) begin
      total++;
      bad++;
      $display("FAIL frame_timeout: frames %0d expected %0d", frame_idx, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_reset", 72'(s_axis_tready), 72'd1);
    @(posedge clk);
    #1;

    // Free-running frame
    send_frame(0, -1, NPIX);
    wait_frames(1);
    chk("f0_w1", cap[0][0], 72'h010203_050607_090A0B);
    chk("f0_w4", cap[0][3], 72'h060708_0A0B0C_0E0F10);
    chk("f0_done_pulses", 72'(done_pulses), 72'd1);

    // Three-cycle stall on window 2
    stall_left = 3;
    send_frame(0, -1, NPIX);
    wait_frames(2);
    chk("f1_w2", cap[1][1], 72'h020304_060708_0A0B0C);
    chk("f1_w3", cap[1][2], 72'h050607_090A0B_0D0E0F);
    chk("f1_w4", cap[1][3], 72'h060708_0A0B0C_0E0F10);
    chk("stall_cycles", 72'(stall_obs), 72'd3);

    // Back-to-back frames
    send_frame(0, -1, NPIX);
    send_frame(16, -1, NPIX);
    wait_frames(4);
    chk("f3_w1", cap[3][0], 72'h111213_151617_191A1B);
    chk("f3_w4", cap[3][3], 72'h161718_1A1B1C_1E1F20);

    // Reset mid-frame, then a clean frame
    send_frame(0, -1, 9);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(0, -1, NPIX);
    wait_frames(5);
    chk("f4_w1", cap[4][0], 72'h010203_050607_090A0B);
    chk("f4_w4", cap[4][3], 72'h060708_0A0B0C_0E0F10);

`ifdef FEEDER_TLAST_CHECK_EN
    // Misplaced tlast on pixel index 2
    send_frame(0, 2, NPIX);
    wait_frames(6);
    chk("err_sticky", 72'(o_err), 72'd1);
    chk("f5_w1", cap[5][0], 72'h010203_050607_090A0B);
`endif

    chk("done_pulse_count", 72'(done_pulses), 72'(frame_idx));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
